r8_window_feeder: RTL and testbench

//   Front end of the radius-8 (17x17) filter datapath. Accepts a raster pixel stream and buffers
//   the last 2*RADIUS rows in shift-register line buffers. Once 2*RADIUS+1 rows are available, it

---
 rtl/r8_window_feeder.sv | 194 +++++++++++++++++++
 tb/tb_r8_window_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/r8_window_feeder.sv
// ---------------------------------------------------------------------------
// r8_window_feeder
//   Front end of the radius-8 filter datapath. It buffers the last 2*RADIUS
//   rows of a raster pixel stream in shift-register line buffers. Once
//   2*RADIUS+1 rows are present, it emits one (2*RADIUS+1)-tall column vector
//   per accepted pixel. It also drives the controller handshake:
//   done_o, col_o and row_eq_max_o.
//
//   Optional feature macro: R8_FEEDER_ERR_EN
//     defined   : err_o is a sticky protocol-error flag.
//     undefined : err_o is tied low and no detection logic is built.
// ---------------------------------------------------------------------------
module r8_window_feeder #(
  parameter int COLS   = 19,
  parameter int ROWS   = 19,
  parameter int RADIUS = 8,
  parameter int DATA_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic                             valid_i,
  input  logic [DATA_W-1:0]                data_i,
  output logic                             ready_o,
  output logic [(2*RADIUS+1)*DATA_W-1:0]   col_vec_o,
  output logic                             col_vec_vld_o,
  output logic [9:0]                       col_o,
  output logic [9:0]                       row_o,
  output logic                             done_o,
  output logic                             row_eq_max_o,
  output logic                             err_o
);

  localparam int               LP_TAPS     = 2 * RADIUS;
  localparam int               LP_VEC_W    = (LP_TAPS + 1) * DATA_W;
  localparam int               LP_LB_W     = COLS * DATA_W;
  localparam logic [9:0]       LP_COL_MAX  = 10'(COLS - 1);
  localparam logic [9:0]       LP_ROW_MAX  = 10'(ROWS - 1);
  localparam logic [9:0]       LP_FILL_ROW = 10'(LP_TAPS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic [9:0]            r_col;
  logic [9:0]            r_row;
  logic [LP_VEC_W-1:0]   r_col_vec;
  logic                  r_col_vec_vld;
  logic [9:0]            r_col_o;
  logic [9:0]            r_row_o;
  logic                  r_done;
  logic                  r_row_eq_max;

  logic                  w_accept;
  logic                  w_col_last;
  logic [DATA_W-1:0]     w_lb_in  [LP_TAPS];
  logic [DATA_W-1:0]     w_lb_out [LP_TAPS];
  logic [LP_VEC_W-1:0]   w_col_vec;

  assign w_accept   = valid_i & r_ready;
  assign w_col_last = (r_col == LP_COL_MAX);

  // Line buffer b holds row (current-2R+b); its oldest pixel is the pixel
  // directly above-by-(2R-b) rows and feeds buffer b-1 on the next accept.
  for (genvar b = 0; b < LP_TAPS; b++) begin : g_lb
    logic [LP_LB_W-1:0] r_line;

    if (b == LP_TAPS - 1) begin : g_top
      assign w_lb_in[b] = data_i;
    end else begin : g_mid
      assign w_lb_in[b] = w_lb_out[b+1];
    end

    assign w_lb_out[b]                 = r_line[LP_LB_W-1 -: DATA_W];
    assign w_col_vec[b*DATA_W +: DATA_W] = w_lb_out[b];

    // Shift one pixel through this row buffer on every accepted pixel
    // NOTE: storage arrays carry no reset; every tap is rewritten by the frame before it is read.
    always_ff @(posedge clk) begin
      if (w_accept) begin
        r_line <= {r_line[LP_LB_W-DATA_W-1:0], w_lb_in[b]};
      end
    end
  end

  assign w_col_vec[LP_TAPS*DATA_W +: DATA_W] = data_i;

  // Frame FSM, raster counters and all registered outputs
  // NOTE: sequential state uses <= only, so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_ready       <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_col_vec     <= '0;
      r_col_vec_vld <= 1'b0;
      r_col_o       <= '0;
      r_row_o       <= '0;
      r_done        <= 1'b0;
      r_row_eq_max  <= 1'b0;
    end else begin
      r_col_vec_vld <= 1'b0;
      r_done        <= 1'b0;

      if (w_accept) begin
        if (r_row >= LP_FILL_ROW) begin
          r_col_vec_vld <= 1'b1;
          r_col_vec     <= w_col_vec;
          r_col_o       <= r_col;
          r_row_o       <= r_row;
        end
        r_done <= (r_row == LP_FILL_ROW) && w_col_last;

        if (w_col_last) begin
          r_col <= '0;
          r_row <= (r_row == LP_ROW_MAX) ? 10'd0 : r_row + 10'd1;
        end else begin
          r_col <= r_col + 10'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_FILL;
            r_ready <= 1'b1;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        ST_FILL: begin
          if (w_accept && (r_row == LP_FILL_ROW) && w_col_last) begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_accept && (r_row == LP_ROW_MAX) && w_col_last) begin
            r_state      <= ST_DONE;
            r_ready      <= 1'b0;
            r_row_eq_max <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start_i) begin
            r_state      <= ST_FILL;
            r_ready      <= 1'b1;
            r_row_eq_max <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef R8_FEEDER_ERR_EN
  logic r_err;

  // Sticky error: pixel offered while not ready, or start while a frame runs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
      r_err <= 1'b0;
    end else if ((valid_i && !r_ready) ||
                 (start_i && ((r_state == ST_FILL) || (r_state == ST_STREAM)))) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign ready_o       = r_ready;
  assign col_vec_o     = r_col_vec;
  assign col_vec_vld_o = r_col_vec_vld;
  assign col_o         = r_col_o;
  assign row_o         = r_row_o;
  assign done_o        = r_done;
  assign row_eq_max_o  = r_row_eq_max;

endmodule

// File: tb/tb_r8_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_r8_window_feeder
//   Scoreboard bench for r8_window_feeder (COLS=ROWS=19, RADIUS=8, DATA_W=8).
//   The driver pushes the expected column vector for every accepted pixel of
//   row >= 16; the monitor pops and compares whenever col_vec_vld_o is high.
//   Compile with +define+R8_FEEDER_ERR_EN to match an RTL built with it.
// ---------------------------------------------------------------------------
module tb_r8_window_feeder;

  localparam int COLS   = 19;
  localparam int ROWS   = 19;
  localparam int RADIUS = 8;
  localparam int DATA_W = 8;
  localparam int VEC_W  = (2*RADIUS+1)*DATA_W;

  typedef logic [VEC_W-1:0] val_t;

  typedef struct {
    val_t       vec;
    logic [9:0] col;
    logic [9:0] row;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  val_t              col_vec_o;
  logic              col_vec_vld_o;
  logic [9:0]        col_o;
  logic [9:0]        row_o;
  logic              done_o;
  logic              row_eq_max_o;
  logic              err_o;

  exp_t q_exp[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_vld   = 0;
  int   n_done  = 0;
  logic exp_done = 1'b0;

  r8_window_feeder #(
    .COLS(COLS), .ROWS(ROWS), .RADIUS(RADIUS), .DATA_W(DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .col_vec_o    (col_vec_o),
    .col_vec_vld_o(col_vec_vld_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .done_o       (done_o),
    .row_eq_max_o (row_eq_max_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic finish_bench();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  endtask

  function automatic logic [DATA_W-1:0] pix(input int r, input int c);
    return DATA_W'((r*COLS + c) % 256);
  endfunction

  function automatic val_t model_vec(input int r, input int c);
    val_t v;
    v = '0;
    for (int k = 0; k <= 2*RADIUS; k++) begin
      v[k*DATA_W +: DATA_W] = pix(r - 2*RADIUS + k, c);
    end
    return v;
  endfunction

  // Monitor: done_o timing every cycle, vectors against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    check("done_o", val_t'(done_o), val_t'(exp_done));
    exp_done = 1'b0;
    if (done_o) n_done++;
    if (col_vec_vld_o) begin
      n_vld++;
      if (q_exp.size() == 0) begin
        check("vld_unexpected", val_t'(1'b1), val_t'(1'b0));
      end else begin
        e = q_exp.pop_front();
        check("col_vec", col_vec_o, e.vec);
        check("col_o", val_t'(col_o), val_t'(e.col));
        check("row_o", val_t'(row_o), val_t'(e.row));
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  // Drive n raster pixels from (0,0); idle_pct is the chance of a gap cycle
  task automatic send_pixels(input int n, input int idle_pct);
    int r, c, waits;
    exp_t e;
    for (int p = 0; p < n; p++) begin
      r = p / COLS;
      c = p % COLS;
      while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
        valid_i = 1'b0;
        @(posedge clk); #1;
      end
      valid_i = 1'b1;
      data_i  = pix(r, c);
      waits   = 0;
      @(negedge clk);
      while (!ready_o) begin
        waits++;
        if (waits > 50) begin
          check("ready_timeout", val_t'(1'b0), val_t'(1'b1));
          finish_bench();
        end
        @(negedge clk);
      end
      @(posedge clk); #1;
      if (r >= 2*RADIUS) begin
        e.vec = model_vec(r, c);
        e.col = 10'(c);
        e.row = 10'(r);
        q_exp.push_back(e);
      end
      if (r == 2*RADIUS && c == COLS-1) exp_done = 1'b1;
    end
    valid_i = 1'b0;
  endtask

  task automatic end_of_frame(input string tag);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_queue_left"}, val_t'(q_exp.size()), val_t'(0));
    check({tag, "_vld_count"}, val_t'(n_vld), val_t'(57));
    check({tag, "_done_count"}, val_t'(n_done), val_t'(1));
    check({tag, "_row_eq_max"}, val_t'(row_eq_max_o), val_t'(1'b1));
    check({tag, "_ready"}, val_t'(ready_o), val_t'(1'b0));
    check({tag, "_err"}, val_t'(err_o), val_t'(1'b0));
  endtask

  initial begin
    rst     = 1'b0;
    start_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;

    // 1. reset held with inputs toggling: all outputs stay zero
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      valid_i = 1'($urandom_range(1));
      start_i = 1'(i % 2);
      data_i  = 8'($urandom_range(255));
      @(negedge clk);
      check("rst_ready", val_t'(ready_o), val_t'(1'b0));
      check("rst_vld", val_t'(col_vec_vld_o), val_t'(1'b0));
      check("rst_outs", val_t'({col_o, row_o, row_eq_max_o, err_o}), val_t'(0));
      check("rst_vec", col_vec_o, val_t'(0));
    end
    valid_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("idle_ready", val_t'(ready_o), val_t'(1'b0));

    // 2/3. full frame back-to-back
    n_vld = 0; n_done = 0;
    pulse_start();
    @(negedge clk);
    check("fill_ready", val_t'(ready_o), val_t'(1'b1));
    @(posedge clk); #1;
    send_pixels(ROWS*COLS, 0);
    end_of_frame("f1");

    // 6. pixel offered in DONE, then cleared by the next start
    @(posedge clk); #1 valid_i = 1'b1;
    @(posedge clk); #1 valid_i = 1'b0;
    @(negedge clk);
`ifdef R8_FEEDER_ERR_EN
    check("err_set", val_t'(err_o), val_t'(1'b1));
`else
    check("err_off", val_t'(err_o), val_t'(1'b0));
`endif
    check("done_hold_rem", val_t'(row_eq_max_o), val_t'(1'b1));
    n_vld = 0; n_done = 0;
    pulse_start();
    @(negedge clk);
    check("err_clear", val_t'(err_o), val_t'(1'b0));
    check("rem_clear", val_t'(row_eq_max_o), val_t'(1'b0));
    check("refill_ready", val_t'(ready_o), val_t'(1'b1));

    // 4. same frame with random idle gaps
    @(posedge clk); #1;
    send_pixels(ROWS*COLS, 30);
    end_of_frame("f2");

    // 5. reset mid-frame after pixel 200, then a clean frame
    n_vld = 0; n_done = 0;
    pulse_start();
    send_pixels(200, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", val_t'(ready_o), val_t'(1'b0));
    check("abort_rem", val_t'(row_eq_max_o), val_t'(1'b0));
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", val_t'(ready_o), val_t'(1'b0));
    check("abort_no_vec", val_t'(n_vld + n_done), val_t'(0));
    pulse_start();
    send_pixels(ROWS*COLS, 0);
    end_of_frame("f3");

    finish_bench();
  end

endmodule
